ccc_clock_monitor: RTL



---
 rtl/ccc_clock_monitor.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/ccc_clock_monitor.sv
// Frequency-band monitor for an MSS CCC generated clock, sampled in the PCLK domain.
// Counts mon_clk rising edges per fixed window, qualifies lock and flags loss of clock.
module ccc_clock_monitor #(
    parameter int WINDOW_CYCLES = 1000,
    parameter int CNT_W         = 16,
    parameter int MIN_EDGES     = 90,
    parameter int MAX_EDGES     = 110,
    parameter int LOCK_WINDOWS  = 4
) (
    input  logic             PCLK,
    input  logic             PRESERN,
    input  logic             enable,
    input  logic             mon_clk,
    input  logic             clear_lost,
    output logic             lock,
    output logic             lost,
    output logic [CNT_W-1:0] measured,
    output logic             meas_valid,
    output logic             in_band,
    output logic [1:0]       state
);

    localparam int WIN_W  = $clog2(WINDOW_CYCLES);
    localparam int GOOD_W = $clog2(LOCK_WINDOWS + 1);

    localparam logic [WIN_W-1:0]  WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);
    localparam logic [GOOD_W-1:0] GOOD_MAX = GOOD_W'(LOCK_WINDOWS);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [CNT_W-1:0]  MIN_V    = CNT_W'(MIN_EDGES);
    localparam logic [CNT_W-1:0]  MAX_V    = CNT_W'(MAX_EDGES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACQ    = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t cur_state;
    state_t nxt_state;

    logic s1;
    logic s2;
    logic s3;
    logic rise;

    logic [WIN_W-1:0]  win_cnt;
    logic [WIN_W-1:0]  win_nxt;
    logic [CNT_W-1:0]  edge_cnt;
    logic [CNT_W-1:0]  edge_nxt;
    logic [CNT_W-1:0]  edge_inc;
    logic [GOOD_W-1:0] good_cnt;
    logic [GOOD_W-1:0] good_nxt;
    logic [GOOD_W-1:0] good_inc;
    logic [CNT_W-1:0]  meas_nxt;
    logic              mv_nxt;
    logic              ib_nxt;
    logic              lost_nxt;
    logic              lock_nxt;
    logic              set_lost;
    logic              win_end;
    logic              band_ok;

    assign rise  = s2 & ~s3;
    assign state = cur_state;

    // Saturating count including a rise seen in the current cycle
    always_comb begin
        edge_inc = edge_cnt;
        if (rise && (edge_cnt != CNT_MAX)) begin
            edge_inc = edge_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        good_inc = good_cnt;
        if (good_cnt != GOOD_MAX) begin
            good_inc = good_cnt + GOOD_W'(1);
        end
    end

    assign win_end = (cur_state != IDLE) && (win_cnt == WIN_LAST);
    assign band_ok = (edge_inc >= MIN_V) && (edge_inc <= MAX_V);

    always_comb begin
        nxt_state = cur_state;
        win_nxt   = win_cnt;
        edge_nxt  = edge_cnt;
        good_nxt  = good_cnt;
        meas_nxt  = measured;
        mv_nxt    = 1'b0;
        ib_nxt    = in_band;
        set_lost  = 1'b0;

        if (!enable) begin
            nxt_state = IDLE;
            win_nxt   = '0;
            edge_nxt  = '0;
            good_nxt  = '0;
        end else begin
            unique case (cur_state)
                IDLE: begin
                    nxt_state = ACQ;
                    win_nxt   = '0;
                    edge_nxt  = '0;
                    good_nxt  = '0;
                end
                ACQ, LOCKED: begin
                    edge_nxt = edge_inc;
                    win_nxt  = win_cnt + WIN_W'(1);
                    if (win_end) begin
                        win_nxt  = '0;
                        edge_nxt = '0;
                        meas_nxt = edge_inc;
                        mv_nxt   = 1'b1;
                        ib_nxt   = band_ok;
                        if (band_ok) begin
                            good_nxt = good_inc;
                            if (good_inc == GOOD_MAX) begin
                                nxt_state = LOCKED;
                            end
                        end else begin
                            good_nxt = '0;
                            if (cur_state == LOCKED) begin
                                nxt_state = ACQ;
                                set_lost  = 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    nxt_state = IDLE;
                    win_nxt   = '0;
                    edge_nxt  = '0;
                    good_nxt  = '0;
                end
            endcase
        end
    end

    // A new loss event takes priority over a firmware clear
    always_comb begin
        lost_nxt = lost;
        if (set_lost) begin
            lost_nxt = 1'b1;
        end else if (clear_lost) begin
            lost_nxt = 1'b0;
        end
    end

    assign lock_nxt = (nxt_state == LOCKED);

    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            s1         <= 1'b0;
            s2         <= 1'b0;
            s3         <= 1'b0;
            cur_state  <= IDLE;
            win_cnt    <= '0;
            edge_cnt   <= '0;
            good_cnt   <= '0;
            measured   <= '0;
            meas_valid <= 1'b0;
            in_band    <= 1'b0;
            lock       <= 1'b0;
            lost       <= 1'b0;
        end else begin
            s1         <= mon_clk;
            s2         <= s1;
            s3         <= s2;
            cur_state  <= nxt_state;
            win_cnt    <= win_nxt;
            edge_cnt   <= edge_nxt;
            good_cnt   <= good_nxt;
            measured   <= meas_nxt;
            meas_valid <= mv_nxt;
            in_band    <= ib_nxt;
            lock       <= lock_nxt;
            lost       <= lost_nxt;
        end
    end

endmodule
